inta_sequencer: RTL and testbench
=================================

// Module: inta_sequencer
// PURPOSE
//   Sequences one 8259 interrupt cycle around the Priority_Resolver: raises INT when the resolver flags a winner,
//   tracks the two-pulse INTA handshake, owns the In-Service register fed back to the resolver, and emits the vector byte.
//   It also services EOI commands (non-specific, specific, rotate-on-EOI) and AEOI.
//   It sits between the resolver/IRR on one side and the data-bus buffer/control logic on the other.
// PARAMETERS
//   LAST_SERVICED_RST  3'd7  reset value of last_serviced (IR0 is highest priority after reset)
// PORTS
//   clk             in   1  system clock, all state updates on rising edge
//   rst             in   1  asynchronous, active-high reset
//   int_flag        in   1  resolver INTFLAG: an unmasked request beats the ISR
//   priority_id     in   3  resolver PriorityID of the winning request
//   rotating        in   1  rotating-priority mode, mirrored to resolver
//   aeoi            in   1  automatic EOI mode (ICW4)
//   t_base          in   5  vector base T7..T3 (ICW2)
//   inta_n          in   1  CPU interrupt acknowledge, active low, synchronous to clk
//   eoi_cmd         in   1  one-cycle pulse: OCW2 EOI command
//   eoi_specific    in   1  qualifies eoi_cmd: 1 = specific (use eoi_level)
//   eoi_rotate      in   1  qualifies eoi_cmd: rotate on EOI
//   eoi_level       in   3  IR level for specific EOI
//   int_out         out  1  INT to CPU
//   isr             out  8  In-Service register, drives resolver IS_status
//   irr_clear       out  8  one-hot one-cycle pulse clearing the acknowledged IRR bit
//   last_serviced   out  3  lowest-priority level for rotation, drives resolver
//   data_out        out  8  vector byte {t_base, id}
//   data_oe         out  1  vector drive enable
//   spurious        out  1  one-cycle pulse: first INTA found no valid request
// BEHAVIOUR
// - Reset: int_out=0, isr=0, irr_clear=0, data_out=0, data_oe=0, spurious=0, last_serviced=LAST_SERVICED_RST, state=IDLE.
// - inta_n is registered once (inta_q). fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
// - State IDLE: if int_flag, go to REQ and assert int_out on the next edge. INTA edges in IDLE are ignored and data_oe stays 0.
// - State REQ: int_out=1.
//   - If int_flag drops before fall, int_out stays high (the CPU must complete the cycle).
//   - On fall: latch id = int_flag ? priority_id : 3'd7.
//     - If the request is valid: set isr[id] and pulse irr_clear[id] for 1 cycle.
//     - Otherwise (spurious): pulse spurious and leave isr unchanged.
//   - On fall: int_out<=0, go to ACK1.
// - ACK1 (first pulse low): wait for rise, then go to GAP. data_oe=0.
// - GAP: wait for fall, then go to ACK2. In the same cycle, data_out<={t_base,id} and data_oe<=1.
// - ACK2: hold data_out and data_oe while inta_n=0. On rise:
//   - data_oe<=0.
//   - If aeoi and not spurious: clear isr[id]; if rotating, last_serviced<=id.
//   - Go to IDLE. A new INT may be raised from the next cycle.
// - EOI is accepted in any state.
//   - Specific: clear isr[eoi_level].
//   - Non-specific: clear the highest-priority set ISR bit. The search starts at last_serviced+1 mod 8 and wraps 7->0.
//   - If the ISR is empty, EOI is a no-op.
//   - When eoi_rotate=1 and a bit was cleared, last_serviced<=cleared level.
// - Same cycle as an ISR set on fall: apply the clear first, then the set. The set wins on the same bit.
// - Priority order in non-rotating mode is fixed 0 (highest) .. 7. last_serviced changes only on rotate events.
// - rst asserted mid-cycle returns everything to reset values immediately. Any in-progress vector is abandoned.
// - All outputs are registered; no combinational path from inputs to outputs.
// TESTING
// - Reset then IDLE: int_flag=1, priority_id=3, t_base=5'h08 -> int_out=1 next cycle.
//   - First INTA: isr=8'h08, irr_clear=8'h08 for 1 cycle.
//   - Second INTA: data_out=8'h43, data_oe=1 while low.
// - aeoi=1, rotating=1, id=5, full cycle -> isr=0 after second rise, last_serviced=5.
// - isr=8'h28, last_serviced=7, non-specific EOI -> isr=8'h20.
//   - With last_serviced=4 instead: isr=8'h08.
//   - eoi_rotate=1: last_serviced follows the cleared level.
// - int_flag drops after int_out rises, before first INTA -> spurious pulse, isr unchanged, second INTA vector = {t_base,3'd7}.
// - Specific EOI level 2 in the same cycle as first-INTA fall with id=2 and isr[2]=1 -> isr[2]=1 (set wins).
// - rst asserted during ACK2 with data_oe=1 -> data_oe=0, isr=0, int_out=0 immediately. The next int_flag starts a clean cycle.

Source files
------------

// File: rtl/inta_sequencer.sv
// 8259 interrupt-cycle sequencer: raises INT, tracks the two-pulse INTA handshake,
// owns the In-Service register and drives the vector byte; also services EOI/AEOI.
module inta_sequencer #(
  parameter logic [2:0] LAST_SERVICED_RST = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_flag,
  input  logic [2:0] priority_id,
  input  logic       rotating,
  input  logic       aeoi,
  input  logic [4:0] t_base,
  input  logic       inta_n,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] irr_clear,
  output logic [2:0] last_serviced,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       spurious
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACK1,
    S_GAP,
    S_ACK2
  } state_t;

  state_t     state, state_nx;
  logic       inta_q;
  logic       fall, rise;
  logic [2:0] id_q, id_nx;
  logic       spur_q, spur_nx;

  logic       int_out_nx;
  logic [7:0] isr_nx;
  logic [7:0] irr_clear_nx;
  logic [2:0] last_serviced_nx;
  logic [7:0] data_out_nx;
  logic       data_oe_nx;
  logic       spurious_nx;

  logic [7:0] set_mask;
  logic [7:0] aeoi_clr;
  logic       aeoi_rot;
  logic       eoi_hit;
  logic [2:0] eoi_sel;
  logic [3:0] ns_pick;

  function automatic logic [7:0] onehot(input logic [2:0] lvl);
    return 8'b1 << lvl;
  endfunction

  // Highest-priority set bit, scanning upward from the level just after ls.
  // Returns {found, level}.
  function automatic logic [3:0] find_highest(input logic [7:0] vec,
                                              input logic [2:0] ls);
    logic [2:0] lvl;
    logic       found;
    logic [2:0] res;
    found = 1'b0;
    res   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      lvl = ls + 3'(i);
      if (!found && vec[lvl]) begin
        found = 1'b1;
        res   = lvl;
      end
    end
    return {found, res};
  endfunction

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nx = state;
    unique case (state)
      S_IDLE: if (int_flag) state_nx = S_REQ;
      S_REQ:  if (fall)     state_nx = S_ACK1;
      S_ACK1: if (rise)     state_nx = S_GAP;
      S_GAP:  if (fall)     state_nx = S_ACK2;
      S_ACK2: if (rise)     state_nx = S_IDLE;
      default:              state_nx = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    int_out_nx   = int_out;
    irr_clear_nx = 8'h00;
    spurious_nx  = 1'b0;
    data_out_nx  = data_out;
    data_oe_nx   = data_oe;
    id_nx        = id_q;
    spur_nx      = spur_q;
    set_mask     = 8'h00;
    aeoi_clr     = 8'h00;
    aeoi_rot     = 1'b0;

    unique case (state)
      S_IDLE: begin
        int_out_nx = int_flag;
        data_oe_nx = 1'b0;
      end
      S_REQ: begin
        // INT stays up even if the request vanishes; the CPU must finish the cycle.
        int_out_nx = 1'b1;
        if (fall) begin
          int_out_nx = 1'b0;
          spur_nx    = ~int_flag;
          if (int_flag) begin
            id_nx        = priority_id;
            set_mask     = onehot(priority_id);
            irr_clear_nx = onehot(priority_id);
          end else begin
            id_nx       = 3'd7;
            spurious_nx = 1'b1;
          end
        end
      end
      S_ACK1: data_oe_nx = 1'b0;
      S_GAP: begin
        if (fall) begin
          data_out_nx = {t_base, id_q};
          data_oe_nx  = 1'b1;
        end
      end
      S_ACK2: begin
        if (rise) begin
          data_oe_nx = 1'b0;
          if (aeoi && !spur_q) begin
            aeoi_clr = onehot(id_q);
            aeoi_rot = rotating;
          end
        end
      end
      default: begin
        int_out_nx = 1'b0;
        data_oe_nx = 1'b0;
      end
    endcase
  end

  // EOI selection; an EOI on an empty (or unset) level clears nothing.
  always_comb begin
    ns_pick = find_highest(isr, last_serviced);
    eoi_hit = 1'b0;
    eoi_sel = 3'd0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        eoi_hit = isr[eoi_level];
        eoi_sel = eoi_level;
      end else begin
        eoi_hit = ns_pick[3];
        eoi_sel = ns_pick[2:0];
      end
    end
  end

  // Clears are applied before the acknowledge set, so a set on the same bit wins.
  always_comb begin
    isr_nx = (isr & ~(eoi_hit ? onehot(eoi_sel) : 8'h00) & ~aeoi_clr) | set_mask;
    last_serviced_nx = last_serviced;
    if (eoi_hit && eoi_rotate) last_serviced_nx = eoi_sel;
    else if (aeoi_rot)         last_serviced_nx = id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inta_q        <= 1'b1;
      id_q          <= 3'd0;
      spur_q        <= 1'b0;
      int_out       <= 1'b0;
      isr           <= 8'h00;
      irr_clear     <= 8'h00;
      last_serviced <= LAST_SERVICED_RST;
      data_out      <= 8'h00;
      data_oe       <= 1'b0;
      spurious      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      inta_q        <= inta_n;
      id_q          <= id_nx;
      spur_q        <= spur_nx;
      int_out       <= int_out_nx;
      isr           <= isr_nx;
      irr_clear     <= irr_clear_nx;
      last_serviced <= last_serviced_nx;
      data_out      <= data_out_nx;
      data_oe       <= data_oe_nx;
      spurious      <= spurious_nx;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: stimulus queues expected events and spot
// checks; a monitor on the falling edge owns all comparisons and the summary.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_flag;
  logic [2:0] priority_id;
  logic       rotating;
  logic       aeoi;
  logic [4:0] t_base;
  logic       inta_n;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic [2:0] last_serviced;
  logic [7:0] data_out;
  logic       data_oe;
  logic       spurious;

  inta_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .int_flag     (int_flag),
    .priority_id  (priority_id),
    .rotating     (rotating),
    .aeoi         (aeoi),
    .t_base       (t_base),
    .inta_n       (inta_n),
    .eoi_cmd      (eoi_cmd),
    .eoi_specific (eoi_specific),
    .eoi_rotate   (eoi_rotate),
    .eoi_level    (eoi_level),
    .int_out      (int_out),
    .isr          (isr),
    .irr_clear    (irr_clear),
    .last_serviced(last_serviced),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .spurious     (spurious)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_INT, EV_IRR, EV_SPUR, EV_OE_ON, EV_OE_OFF} ev_t;
  typedef struct packed {ev_t kind; logic [7:0] val;} exp_t;
  typedef struct {string name; logic [15:0] act; logic [15:0] exp;} chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  logic prev_int = 1'b0;
  logic prev_oe  = 1'b0;

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic observe(input ev_t kind, input logic [7:0] val);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s/%h expected nothing", kind.name(), val);
    end else begin
      e = exp_q.pop_front();
      check({"event_", e.kind.name()}, {5'b0, kind, val}, {5'b0, e.kind, e.val});
    end
  endtask

  always @(negedge clk) begin
    chk_t c;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      check(c.name, c.act, c.exp);
    end
    if (int_out && !prev_int)  observe(EV_INT, isr);
    if (irr_clear != 8'h00)    observe(EV_IRR, irr_clear);
    if (spurious)              observe(EV_SPUR, isr);
    if (data_oe && !prev_oe)   observe(EV_OE_ON, data_out);
    if (!data_oe && prev_oe)   observe(EV_OE_OFF, isr);
    prev_int = int_out;
    prev_oe  = data_oe;
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic push(input ev_t kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic raise(input logic [2:0] id);
    int_flag    = 1'b1;
    priority_id = id;
    tick();
    expect_val("int_out_raised", 16'(int_out), 16'd1);
  endtask

  task automatic first_ack(input logic [7:0] exp_isr, input bit with_eoi, input logic [2:0] lvl);
    inta_n = 1'b0;
    if (with_eoi) begin
      eoi_cmd      = 1'b1;
      eoi_specific = 1'b1;
      eoi_level    = lvl;
    end
    tick();
    eoi_cmd      = 1'b0;
    eoi_specific = 1'b0;
    int_flag     = 1'b0;
    expect_val("isr_after_fall", 16'(isr), 16'(exp_isr));
    expect_val("int_out_dropped", 16'(int_out), 16'd0);
    tick();
    expect_val("irr_clear_one_cycle", 16'(irr_clear), 16'd0);
    inta_n = 1'b1;
    tick();
  endtask

  task automatic second_ack(input int low_cycles, input logic [7:0] exp_vec);
    inta_n = 1'b0;
    tick();
    expect_val("vector", 16'(data_out), 16'(exp_vec));
    repeat (low_cycles) tick();
    expect_val("data_oe_hold", 16'(data_oe), 16'd1);
    inta_n = 1'b1;
    tick();
    expect_val("data_oe_release", 16'(data_oe), 16'd0);
  endtask

  task automatic eoi(input bit spec, input bit rot, input logic [2:0] lvl);
    eoi_cmd      = 1'b1;
    eoi_specific = spec;
    eoi_rotate   = rot;
    eoi_level    = lvl;
    tick();
    eoi_cmd      = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate   = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    rst = 1'b1; int_flag = 1'b0; priority_id = 3'd0; rotating = 1'b0; aeoi = 1'b0;
    t_base = 5'h00; inta_n = 1'b1; eoi_cmd = 1'b0; eoi_specific = 1'b0;
    eoi_rotate = 1'b0; eoi_level = 3'd0;
    repeat (3) tick();
    expect_val("rst_int_out", 16'(int_out), 16'd0);
    expect_val("rst_isr", 16'(isr), 16'd0);
    expect_val("rst_irr_clear", 16'(irr_clear), 16'd0);
    expect_val("rst_last_serviced", 16'(last_serviced), 16'd7);
    expect_val("rst_data_out", 16'(data_out), 16'd0);
    expect_val("rst_data_oe", 16'(data_oe), 16'd0);
    expect_val("rst_spurious", 16'(spurious), 16'd0);
    rst = 1'b0;
    tick();

    // Basic cycle, id=3, base 0x08 -> vector 0x43, then non-specific EOI.
    t_base = 5'h08;
    push(EV_INT, 8'h00);    raise(3'd3);
    push(EV_IRR, 8'h08);    first_ack(8'h08, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h43);  push(EV_OE_OFF, 8'h08);
    second_ack(2, 8'h43);
    eoi(1'b0, 1'b0, 3'd0);
    expect_val("eoi_basic_isr", 16'(isr), 16'h00);

    // AEOI + rotating, id=5.
    aeoi = 1'b1; rotating = 1'b1;
    push(EV_INT, 8'h00);    raise(3'd5);
    push(EV_IRR, 8'h20);    first_ack(8'h20, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h45);  push(EV_OE_OFF, 8'h00);
    second_ack(1, 8'h45);
    expect_val("aeoi_isr", 16'(isr), 16'h00);
    expect_val("aeoi_last_serviced", 16'(last_serviced), 16'd5);
    aeoi = 1'b0; rotating = 1'b0;

    // Build isr=0x28 with last_serviced=7, then non-specific EOI searches.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    expect_val("rst2_last_serviced", 16'(last_serviced), 16'd7);
    push(EV_INT, 8'h00);    raise(3'd3);
    push(EV_IRR, 8'h08);    first_ack(8'h08, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h43);  push(EV_OE_OFF, 8'h08);
    second_ack(0, 8'h43);
    push(EV_INT, 8'h08);    raise(3'd5);
    push(EV_IRR, 8'h20);    first_ack(8'h28, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h45);  push(EV_OE_OFF, 8'h28);
    second_ack(0, 8'h45);
    eoi(1'b0, 1'b0, 3'd0);
    expect_val("ns_eoi_ls7", 16'(isr), 16'h20);
    push(EV_INT, 8'h20);    raise(3'd3);
    push(EV_IRR, 8'h08);    first_ack(8'h28, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h43);  push(EV_OE_OFF, 8'h28);
    second_ack(0, 8'h43);
    // AEOI-rotate on level 4 moves last_serviced to 4 without touching bits 3/5.
    aeoi = 1'b1; rotating = 1'b1;
    push(EV_INT, 8'h28);    raise(3'd4);
    push(EV_IRR, 8'h10);    first_ack(8'h38, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h44);  push(EV_OE_OFF, 8'h28);
    second_ack(0, 8'h44);
    aeoi = 1'b0; rotating = 1'b0;
    expect_val("ls_after_rot4", 16'(last_serviced), 16'd4);
    eoi(1'b0, 1'b0, 3'd0);
    expect_val("ns_eoi_ls4", 16'(isr), 16'h08);
    expect_val("ns_eoi_ls_kept", 16'(last_serviced), 16'd4);
    eoi(1'b0, 1'b1, 3'd0);
    expect_val("rot_eoi_isr", 16'(isr), 16'h00);
    expect_val("rot_eoi_ls", 16'(last_serviced), 16'd3);
    eoi(1'b0, 1'b1, 3'd0);
    expect_val("empty_eoi_ls", 16'(last_serviced), 16'd3);

    // Spurious: request vanishes before the first INTA.
    aeoi = 1'b1; rotating = 1'b1;
    push(EV_INT, 8'h00);    raise(3'd2);
    int_flag = 1'b0;
    tick();
    expect_val("int_out_held", 16'(int_out), 16'd1);
    push(EV_SPUR, 8'h00);   first_ack(8'h00, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h47);  push(EV_OE_OFF, 8'h00);
    second_ack(1, 8'h47);
    expect_val("spur_ls", 16'(last_serviced), 16'd3);
    aeoi = 1'b0; rotating = 1'b0;

    // Specific EOI colliding with the ISR set on the same level: set wins.
    push(EV_INT, 8'h00);    raise(3'd2);
    push(EV_IRR, 8'h04);    first_ack(8'h04, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h42);  push(EV_OE_OFF, 8'h04);
    second_ack(0, 8'h42);
    push(EV_INT, 8'h04);    raise(3'd2);
    push(EV_IRR, 8'h04);    first_ack(8'h04, 1'b1, 3'd2);
    push(EV_OE_ON, 8'h42);  push(EV_OE_OFF, 8'h04);
    second_ack(0, 8'h42);
    eoi(1'b1, 1'b0, 3'd2);
    expect_val("spec_eoi_isr", 16'(isr), 16'h00);

    // Reset during ACK2 abandons the vector; next request runs clean.
    push(EV_INT, 8'h00);    raise(3'd1);
    push(EV_IRR, 8'h02);    first_ack(8'h02, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h41);
    inta_n = 1'b0;
    tick();
    expect_val("ack2_oe", 16'(data_oe), 16'd1);
    push(EV_OE_OFF, 8'h00);
    #2 rst = 1'b1; inta_n = 1'b1;
    #1;
    expect_val("midrst_data_oe", 16'(data_oe), 16'd0);
    expect_val("midrst_isr", 16'(isr), 16'd0);
    expect_val("midrst_int_out", 16'(int_out), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    push(EV_INT, 8'h00);    raise(3'd6);
    push(EV_IRR, 8'h40);    first_ack(8'h40, 1'b0, 3'd0);
    push(EV_OE_ON, 8'h46);  push(EV_OE_OFF, 8'h40);
    second_ack(1, 8'h46);

    repeat (3) tick();
    done = 1'b1;
  end

endmodule
